// File: rtl/alu_r32i.sv
// Single-cycle-latency RV32I-style ALU: shared add/sub/compare path, one log shifter, registered result.
// Optional registered zero flag is enabled by defining ALU_R32I_ZERO_FLAG_EN.
module alu_r32i #(
  parameter int dataW = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [dataW-1:0] A,
  input  logic [dataW-1:0] B,
  input  logic [3:0]       alucode,
  output logic [dataW-1:0] result
`ifdef ALU_R32I_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int SHW = 5;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SSL  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SSR  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111,
    OP_SUB  = 4'b1000,
    OP_SRA  = 4'b1101,
    OP_CPY  = 4'b1111
  } alu_op_e;

  // Shared adder: SUB, SLT and SLTU all use A + ~B + 1.
  logic             sub;
  logic [dataW-1:0] b_op;
  logic [dataW:0]   sum_ext;
  logic [dataW-1:0] sum;
  logic             carry;
  logic             lt_s;
  logic             lt_u;

  assign sub     = (alucode == OP_SUB) || (alucode == OP_SLT) || (alucode == OP_SLTU);
  assign b_op    = sub ? ~B : B;
  assign sum_ext = {1'b0, A} + {1'b0, b_op} + {{dataW{1'b0}}, sub};
  assign sum     = sum_ext[dataW-1:0];
  assign carry   = sum_ext[dataW];
  assign lt_u    = ~carry;
  // Differing signs decide signed order directly; otherwise the difference cannot overflow.
  assign lt_s    = (A[dataW-1] != B[dataW-1]) ? A[dataW-1] : sum[dataW-1];

  // Single right shifter; left shifts go through it bit-reversed.
  logic             left;
  logic             fill;
  logic [SHW-1:0]   shamt;
  logic [dataW-1:0] a_rev;
  logic [dataW-1:0] sh_in;
  logic [dataW-1:0] sh_out;
  logic [dataW-1:0] sh_rev;
  logic [dataW-1:0] sh_stage [0:SHW];

  assign left  = (alucode == OP_SSL);
  assign fill  = (alucode == OP_SRA) & A[dataW-1];
  assign shamt = B[SHW-1:0];

  always_comb begin
    a_rev = '0;
    for (int i = 0; i < dataW; i++) a_rev[i] = A[dataW-1-i];
  end

  assign sh_in       = left ? a_rev : A;
  assign sh_stage[0] = sh_in;

  for (genvar s = 0; s < SHW; s++) begin : g_shift
    localparam int D = 1 << s;
    assign sh_stage[s+1] = shamt[s] ? {{D{fill}}, sh_stage[s][dataW-1:D]} : sh_stage[s];
  end

  always_comb begin
    sh_rev = '0;
    for (int i = 0; i < dataW; i++) sh_rev[i] = sh_stage[SHW][dataW-1-i];
  end

  assign sh_out = left ? sh_rev : sh_stage[SHW];

  logic [dataW-1:0] nxt;

  always_comb begin
    nxt = '0;
    case (alucode)
      OP_ADD,
      OP_SUB:  nxt = sum;
      OP_SLT:  nxt = {{(dataW-1){1'b0}}, lt_s};
      OP_SLTU: nxt = {{(dataW-1){1'b0}}, lt_u};
      OP_XOR:  nxt = A ^ B;
      OP_OR:   nxt = A | B;
      OP_AND:  nxt = A & B;
      OP_SSL,
      OP_SSR,
      OP_SRA:  nxt = sh_out;
      OP_CPY:  nxt = B;
      default: nxt = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) result <= '0;
    else       result <= nxt;
  end

`ifdef ALU_R32I_ZERO_FLAG_EN
  always_ff @(posedge clock) begin
    if (reset) zero <= 1'b1;
    else       zero <= (nxt == '0);
  end
`endif

endmodule

// File: tb/tb_alu_r32i.sv
// Self-checking bench for alu_r32i: directed cases then randomized ops against a plain-arithmetic model.
module tb_alu_r32i;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  alucode = '0;
  logic [31:0] result;
`ifdef ALU_R32I_ZERO_FLAG_EN
  logic        zero;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  alu_r32i #(.dataW(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .alucode (alucode),
    .result  (result)
`ifdef ALU_R32I_ZERO_FLAG_EN
    ,
    .zero    (zero)
`endif
  );

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a << sh;
      4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a ^ b;
      4'd5:    return a >> sh;
      4'd6:    return a | b;
      4'd7:    return a & b;
      4'd8:    return a - b;
      4'd13:   return $signed(a) >>> sh;
      4'd15:   return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag, input logic [31:0] exp);
`ifdef ALU_R32I_ZERO_FLAG_EN
    tests++;
    assert (zero === (exp == 32'd0)) else begin
      fails++;
      $error("FAIL %s.zero: observed %b, expected %b", tag, zero, exp == 32'd0);
    end
`else
    if (exp === 32'hx) $display("unreachable %s", tag);
`endif
  endtask

  // Present inputs mid-cycle, then sample just after the next rising edge.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input logic rst);
    @(negedge clock);
    A = a; B = b; alucode = op; reset = rst;
    @(posedge clock);
    #1;
  endtask

  task automatic op_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] exp);
    step(a, b, op, 1'b0);
    check(tag, result, exp);
    check_zero(tag, exp);
  endtask

  initial begin
    logic [31:0] ra, rb, exp, held;
    logic [3:0]  rop;
    logic        rrst;

    step(32'd0, 32'd0, 4'd0, 1'b1);
    check("reset", result, 32'd0);
    check_zero("reset", 32'd0);

    op_chk("add_after_reset", 32'd9, 32'd4, 4'b0000, 32'd13);
    op_chk("slt_9_4",   32'd9,  32'd4,  4'b0010, 32'd0);
    op_chk("slt_2_4",   32'd2,  32'd4,  4'b0010, 32'd1);
    op_chk("sltu_2_4",  32'd2,  32'd4,  4'b0011, 32'd1);
    op_chk("sltu_m2_4", -32'sd2, 32'd4, 4'b0011, 32'd0);
    op_chk("sltu_m2_m1", -32'sd2, -32'sd1, 4'b0011, 32'd1);
    op_chk("and",  32'd9, 32'd5, 4'b0111, 32'd1);
    op_chk("or",   32'd9, 32'd5, 4'b0110, 32'd13);
    op_chk("xor",  32'd9, 32'd5, 4'b0100, 32'd12);
    op_chk("sub",  32'd9, 32'd4, 4'b1000, 32'd5);
    op_chk("ssl_1", 32'd9, 32'd1, 4'b0001, 32'd18);
    op_chk("ssl_3", 32'd9, 32'd3, 4'b0001, 32'd72);
    op_chk("ssr_3", 32'd9, 32'd3, 4'b0101, 32'd1);
    op_chk("sra_3", 32'd9, 32'd3, 4'b1101, 32'd1);
    op_chk("sra_neg", -32'sd9, 32'd3, 4'b1101, -32'sd2);
    op_chk("ssr_neg", -32'sd9, 32'd3, 4'b0101, 32'h1FFF_FFFE);
    op_chk("ssl_b35", 32'd9, 32'd35, 4'b0001, 32'd72);
    op_chk("sra_sh0", -32'sd9, 32'hFFFF_FFE0, 4'b1101, -32'sd9);
    op_chk("ssl_sh31", 32'd3, 32'd31, 4'b0001, 32'h8000_0000);
    op_chk("cpy",  -32'sd9, 32'd3, 4'b1111, 32'd3);
    op_chk("unlisted_1010", 32'd9, 32'd4, 4'b1010, 32'd0);
    op_chk("slt_minmax", 32'h8000_0000, 32'h7FFF_FFFF, 4'b0010, 32'd1);
    op_chk("add_wrap", 32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0);

    step(32'd9, 32'd4, 4'b0000, 1'b1);
    check("reset_wins", result, 32'd0);
    check_zero("reset_wins", 32'd0);
    op_chk("resume", 32'd9, 32'd4, 4'b0000, 32'd13);

    op_chk("sub_zero", 32'd5, 32'd5, 4'b1000, 32'd0);
    op_chk("add_nonzero", 32'd5, 32'd5, 4'b0000, 32'd10);

    for (int i = 0; i < 300; i++) begin
      ra   = $urandom;
      rb   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rop  = 4'($urandom_range(0, 15));
      rrst = ($urandom_range(0, 19) == 0);
      step(ra, rb, rop, rrst);
      exp = rrst ? 32'd0 : model(ra, rb, rop);
      check($sformatf("rand%0d_op%0d", i, rop), result, exp);
      check_zero($sformatf("rand%0d", i), exp);
      // Inputs wiggling between edges must not disturb the registered value.
      held = exp;
      A = $urandom; B = $urandom; alucode = 4'($urandom_range(0, 15));
      #2;
      check($sformatf("hold%0d", i), result, held);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_r32i.md
ALU_R32I -- requirements
Module: alu_r32i

Interface
REQ-001 SHALL have parameter: dataW, 32, datapath width in bits for A, B and result.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 SHALL have port: A  input  dataW  operand A, signed two's complement.
REQ-005 SHALL have port: B  input  dataW  operand B, signed two's complement; its low 5 bits are the shift amount.
REQ-006 SHALL have port: alucode  input  4  operation select.
REQ-007 SHALL have port: result  output  dataW  registered operation result, signed.

Function
REQ-008 SHALL use alucode encodings ADD=4'b0000, SSL=4'b0001, SLT=4'b0010, SLTU=4'b0011, XOR=4'b0100, SSR=4'b0101, OR=4'b0110, AND=4'b0111, SUB=4'b1000, SRA=4'b1101, CPY=4'b1111.
REQ-009 SHALL compute ADD as A+B and SUB as A-B, modulo 2^dataW; overflow and carry are discarded.
REQ-010 SHALL compute SLT as 1 when signed A < signed B, else 0, zero-extended to dataW.
REQ-011 SHALL compute SLTU as 1 when unsigned A < unsigned B, else 0, zero-extended to dataW.
REQ-012 SHALL compute AND, OR and XOR bitwise over all dataW bits.
REQ-013 SHALL compute SSL as A shifted left logically by B[4:0], filling with zeros.
REQ-014 SHALL compute SSR as A shifted right logically by B[4:0], filling with zeros.
REQ-015 SHALL compute SRA as A shifted right arithmetically by B[4:0], filling with A's sign bit.
REQ-016 SHALL ignore B[dataW-1:5] for all shift operations; a shift amount of 0 SHALL return A unchanged.
REQ-017 SHALL compute CPY as B passed through unchanged (LUI path).
REQ-018 SHALL produce 0 for any unlisted alucode value.
REQ-019 SHALL register the result: the value computed from A, B and alucode sampled at rising edge N SHALL appear on result after edge N, giving 1-cycle latency.
REQ-020 SHALL accept a new operation every cycle, with no handshake and no stall.
REQ-021 SHALL hold result stable between rising edges regardless of input changes.

Reset
REQ-022 SHALL load result with 0 on any rising edge where reset=1.
REQ-023 SHALL give reset priority over the computed value when both occur on the same edge; the operation presented on that edge is lost.
REQ-024 SHALL resume normal computation on the first rising edge after reset is deasserted.

Configuration
REQ-025 SHALL, when macro ALU_R32I_ZERO_FLAG_EN is defined, add port zero (output, 1 bit), registered alongside result and equal to 1 exactly when the registered result is all zeros.
REQ-026 SHALL reset zero to 1 when ALU_R32I_ZERO_FLAG_EN is defined, consistent with result=0.
REQ-027 SHALL omit the zero port and its register entirely when ALU_R32I_ZERO_FLAG_EN is undefined; result behaviour SHALL be identical in both builds.

Verification
REQ-028 SHALL pass: reset=1 for one edge, then deassert -> result=0 after the reset edge, and 13 one edge after applying A=9, B=4, ADD.
REQ-029 SHALL pass: A=9, B=4, SLT -> 0; A=2, SLT -> 1; A=2, SLTU -> 1; A=-2, B=4, SLTU -> 0; A=-2, B=-1, SLTU -> 1.
REQ-030 SHALL pass: A=9, B=5 -> AND gives 1, OR gives 13, XOR gives 12; A=9, B=4, SUB -> 5.
REQ-031 SHALL pass: A=9, B=1, SSL -> 18; B=3, SSL -> 72; B=3, SSR -> 1; B=3, SRA -> 1; A=-9, B=3, SRA -> -2; A=-9, B=3, SSR -> 0x1FFFFFFE; B=35, SSL on A=9 -> 72.
REQ-032 SHALL pass: A=-9, B=3, CPY -> 3; alucode=4'b1010 -> 0; reset asserted on the same edge as ADD -> 0.
REQ-033 SHALL pass, with ALU_R32I_ZERO_FLAG_EN defined: A=5, B=5, SUB -> result=0, zero=1; then ADD -> result=10, zero=0.
